gmii_tx_framer: RTL and testbench
=================================

Name: gmii_tx_framer

Overview:
- Transmit-side counterpart of the RGMII/GMII receive path: converts a byte stream (valid/ready/last) into a complete GMII Ethernet frame on gmii_txd/gmii_tx_en.
- Adds preamble, SFD, optional minimum-length padding and CRC32 FCS, then enforces the inter-frame gap.
- Sits between the MAC/packet builder and the RGMII DDR output stage, in the gmii_tx_clk domain (125 MHz).

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD (legal 1..15)
- IFG_BYTES, 12, minimum idle cycles (gmii_tx_en low) after the last FCS byte (legal 1..255)
- MIN_DATA_LEN, 60, minimum data+pad byte count before FCS; used only with GMII_TX_PAD_EN

Ports:
- gmii_tx_clk  in   1  GMII transmit clock; all logic on rising edge
- rst          in   1  asynchronous, active-high reset
- s_data       in   8  payload byte (destination MAC onward)
- s_valid      in   1  s_data valid
- s_last       in   1  qualifies the final payload byte
- s_ready      out  1  byte accepted on an edge where s_valid & s_ready
- gmii_tx_en   out  1  GMII transmit enable, registered
- gmii_txd     out  8  GMII transmit data, registered
- gmii_tx_er   out  1  GMII transmit error, registered
- frame_done   out  1  one-cycle pulse; the last FCS byte is on gmii_txd
- underflow    out  1  one-cycle pulse; the frame was aborted by a source stall

Behaviour:
- Reset (asynchronous): gmii_tx_en=0, gmii_txd=0x00, gmii_tx_er=0, s_ready=0, frame_done=0, underflow=0, state=IDLE, CRC=0xFFFFFFFF, counters=0. No IFG is enforced after reset release.
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- IDLE -> PREAMBLE:
  - Triggered when s_valid=1 at edge N. The byte is not consumed.
  - Edges N+1..N+PREAMBLE_LEN drive gmii_tx_en=1, gmii_txd=0x55.
  - Edge N+PREAMBLE_LEN+1 drives 0xD5 (SFD).
- s_ready:
  - Combinational: high in SFD and DATA, low in every other state.
  - A byte accepted at edge k appears on gmii_txd after edge k (1-cycle latency, no bubbles).
  - The first payload byte follows the SFD directly.
- DATA:
  - Each accepted byte is fed into the CRC and increments a saturating 11-bit byte counter (saturates at 2047, no length limit).
  - s_last accepted: go to PAD if GMII_TX_PAD_EN is defined and count < MIN_DATA_LEN, otherwise go to FCS.
- Underflow:
  - Condition: in DATA, s_valid=0 before s_last has been accepted.
  - Next edge drives gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00 for one cycle and pulses underflow.
  - Then go to IFG with no FCS. Remaining source bytes up to and including s_last are dropped while in IFG/IDLE (s_ready=0 does not consume them; the source must flush).
  - Underflow in SFD (s_valid low when SFD is driven) is treated identically.
- PAD: drive 0x00 bytes, each included in the CRC, until count = MIN_DATA_LEN, then go to FCS.
- FCS:
  - CRC: IEEE 802.3 CRC32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, computed over data+pad.
  - Transmitted value is the complement of the CRC register, sent as 4 bytes, least-significant byte first.
  - frame_done pulses while the 4th byte is driven.
- IFG:
  - gmii_tx_en=0, gmii_txd=0x00 for exactly IFG_BYTES cycles, then IDLE.
  - s_valid during IFG is ignored (not accepted).
  - Back-to-back frames therefore have exactly IFG_BYTES idle cycles between them.
- CRC register and byte counter reinitialise on entry to PREAMBLE.
- gmii_tx_er=0 at all times except the underflow cycle.
- Reset asserted mid-frame: outputs drop immediately (asynchronous); the partial frame is truncated with no error byte.

Optional Feature:
- GMII_TX_PAD_EN defined: frames with fewer than MIN_DATA_LEN payload bytes are zero-padded to MIN_DATA_LEN before the FCS (64-byte minimum on the wire excluding preamble).
- Undefined: no PAD state. The FCS immediately follows the last payload byte regardless of length; the PAD logic and MIN_DATA_LEN comparison are not synthesised.

Test Plan:
- Macro off; send ASCII "123456789" (9 bytes, s_last on 0x39), s_valid held high.
  - Required wire sequence: 7x0x55, 0xD5, 31..39, then 0x26 0x39 0xF4 0xCB.
  - frame_done pulses with 0xCB; gmii_tx_en high for exactly 21 cycles.
- Macro on; send 14-byte frame.
  - 46 bytes of 0x00 pad follow the payload, then 4 FCS bytes.
  - gmii_tx_en high for 8+60+4=72 cycles; FCS matches a software CRC32 of 60 bytes.
- Two 64-byte frames presented back-to-back, s_valid continuously high.
  - Exactly 12 cycles of gmii_tx_en=0 between the last FCS byte and the next 0x55.
  - s_ready low throughout the IFG.
- Drop s_valid for one cycle after payload byte 20.
  - One cycle of tx_en=1, tx_er=1, txd=0x00, and an underflow pulse.
  - No FCS bytes, then 12 idle cycles.
- Assert rst during payload byte 30.
  - gmii_tx_en=0 and gmii_txd=0x00 with no clock edge needed.
  - After release, a new frame starts its preamble on the cycle after s_valid is seen (no IFG).
- Deassert s_valid in IDLE for 100 cycles → gmii_tx_en stays 0 and s_ready stays 0.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, optional zero padding, CRC32 FCS and inter-frame gap.
// Optional padding to MIN_DATA_LEN is compiled in when GMII_TX_PAD_EN is defined.
module gmii_tx_framer #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_BYTES    = 12,
    parameter int unsigned MIN_DATA_LEN = 60
) (
    input  logic       gmii_tx_clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_er,
    output logic       frame_done,
    output logic       underflow
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;

`ifdef GMII_TX_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    localparam logic [3:0]  PRE_N    = 4'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 2);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_DATA_LEN);
    // With a 1-cycle gap the IDLE cycle itself is the whole gap.
    localparam state_t      AFTER_FRAME = (IFG_BYTES > 1) ? IFG : IDLE;

    state_t      state_q;
    logic [3:0]  pre_cnt_q;
    logic [10:0] byte_cnt_q;
    logic [1:0]  fcs_idx_q;
    logic [7:0]  ifg_cnt_q;
    logic [31:0] crc_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic [7:0]  txd_q;
    logic        done_q;
    logic        uf_q;

    logic [7:0]  crc_in_d;
    logic [31:0] crc_d;
    logic [10:0] cnt_d;
    logic [31:0] fcs_d;
    logic [7:0]  fcs_byte_d;
    logic        short_frame_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Pad bytes enter the CRC as zeros; payload bytes come straight from the source.
    assign crc_in_d      = (state_q == SFD || state_q == DATA) ? s_data : 8'h00;
    assign crc_d         = crc32_byte(crc_q, crc_in_d);
    assign cnt_d         = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign short_frame_d = PadEn && (cnt_d < MIN_CNT);
    assign fcs_d         = ~crc_q;

    always_comb begin
        fcs_byte_d = fcs_d[7:0];
        case (fcs_idx_q)
            2'd0: fcs_byte_d = fcs_d[7:0];
            2'd1: fcs_byte_d = fcs_d[15:8];
            2'd2: fcs_byte_d = fcs_d[23:16];
            2'd3: fcs_byte_d = fcs_d[31:24];
            default: fcs_byte_d = fcs_d[7:0];
        endcase
    end

    assign s_ready    = (state_q == SFD) || (state_q == DATA);
    assign gmii_tx_en = tx_en_q;
    assign gmii_txd   = txd_q;
    assign gmii_tx_er = tx_er_q;
    assign frame_done = done_q;
    assign underflow  = uf_q;

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            byte_cnt_q <= '0;
            fcs_idx_q  <= '0;
            ifg_cnt_q  <= '0;
            crc_q      <= 32'hFFFFFFFF;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            txd_q      <= 8'h00;
            done_q     <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            tx_er_q <= 1'b0;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_en_q <= 1'b0;
                    txd_q   <= 8'h00;
                    // The first byte is only observed here; it is consumed after the SFD.
                    if (s_valid) begin
                        state_q    <= PREAMBLE;
                        pre_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        crc_q      <= 32'hFFFFFFFF;
                    end
                end
                PREAMBLE: begin
                    tx_en_q <= 1'b1;
                    if (pre_cnt_q == PRE_N) begin
                        txd_q   <= 8'hD5;
                        state_q <= SFD;
                    end else begin
                        txd_q     <= 8'h55;
                        pre_cnt_q <= pre_cnt_q + 4'd1;
                    end
                end
                SFD, DATA: begin
                    tx_en_q <= 1'b1;
                    if (s_valid) begin
                        txd_q      <= s_data;
                        crc_q      <= crc_d;
                        byte_cnt_q <= cnt_d;
                        if (s_last) begin
                            fcs_idx_q <= '0;
                            state_q   <= short_frame_d ? PAD : FCS;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        // Source stalled mid-frame: poison the frame and skip the FCS.
                        txd_q     <= 8'h00;
                        tx_er_q   <= 1'b1;
                        uf_q      <= 1'b1;
                        ifg_cnt_q <= '0;
                        state_q   <= AFTER_FRAME;
                    end
                end
`ifdef GMII_TX_PAD_EN
                PAD: begin
                    tx_en_q    <= 1'b1;
                    txd_q      <= 8'h00;
                    crc_q      <= crc_d;
                    byte_cnt_q <= cnt_d;
                    if (cnt_d == MIN_CNT) state_q <= FCS;
                end
`endif
                FCS: begin
                    tx_en_q   <= 1'b1;
                    txd_q     <= fcs_byte_d;
                    fcs_idx_q <= fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        done_q    <= 1'b1;
                        ifg_cnt_q <= '0;
                        state_q   <= AFTER_FRAME;
                    end
                end
                IFG: begin
                    tx_en_q <= 1'b0;
                    txd_q   <= 8'h00;
                    if (ifg_cnt_q == IFG_LAST) state_q <= IDLE;
                    else                       ifg_cnt_q <= ifg_cnt_q + 8'd1;
                end
                default: begin
                    tx_en_q <= 1'b0;
                    txd_q   <= 8'h00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: a frame-level wire model (byte lists per frame plus gap rule) compared every cycle.
module tb_gmii_tx_framer;
    localparam int P   = 7;
    localparam int IFG = 12;
    localparam int MIN = 60;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] d;
        logic       done;
        logic       uf;
        logic       rdy;
    } ent_t;

    logic       gmii_tx_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, gmii_tx_en, gmii_tx_er, frame_done, underflow;
    logic [7:0] gmii_txd;

    int total = 0;
    int bad = 0;

    ent_t exp_q[$];
    int   len_q[$];
    int   cur_left = 0;
    int   gap_left = 0;
    bq_t  obs;
    int   idle_run = 0;
    int   last_gap = 0;

    gmii_tx_framer #(.PREAMBLE_LEN(P), .IFG_BYTES(IFG), .MIN_DATA_LEN(MIN)) dut (
        .gmii_tx_clk(gmii_tx_clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .gmii_tx_er(gmii_tx_er),
        .frame_done(frame_done), .underflow(underflow)
    );

    always #4 gmii_tx_clk = ~gmii_tx_clk;

    function automatic logic [31:0] crc32_ref(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
        end
        return ~c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Expected wire image of one frame; uf_at>0 means the source stalls after uf_at bytes.
    task automatic push_frame(input bq_t p, input int uf_at);
        bq_t body;
        logic [31:0] c;
        int n = 0;
        for (int i = 0; i < P; i++) begin exp_q.push_back('{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0}); n++; end
        exp_q.push_back('{1'b1, 1'b0, 8'hD5, 1'b0, 1'b0, 1'b1}); n++;
        if (uf_at > 0) begin
            for (int i = 0; i < uf_at; i++) begin exp_q.push_back('{1'b1, 1'b0, p[i], 1'b0, 1'b0, 1'b1}); n++; end
            exp_q.push_back('{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0}); n++;
        end else begin
            for (int i = 0; i < p.size(); i++) begin
                body.push_back(p[i]);
                exp_q.push_back('{1'b1, 1'b0, p[i], 1'b0, 1'b0, (i != p.size() - 1)}); n++;
            end
`ifdef GMII_TX_PAD_EN
            while (body.size() < MIN) begin
                body.push_back(8'h00);
                exp_q.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}); n++;
            end
`endif
            c = crc32_ref(body);
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back('{1'b1, 1'b0, c[8*k +: 8], (k == 3), 1'b0, 1'b0}); n++;
            end
        end
        len_q.push_back(n);
    endtask

    // Compare process: one model step per clock edge, outputs checked 2 ns later.
    initial begin : cmp
        ent_t e;
        logic sv, rs;
        forever begin
            @(posedge gmii_tx_clk);
            sv = s_valid;
            rs = rst;
            #2;
            e = '0;
            if (rs) begin
                cur_left = 0; gap_left = 0;
                exp_q.delete(); len_q.delete();
            end else if (cur_left > 0) begin
                e = exp_q.pop_front();
                cur_left--;
                if (cur_left == 0) gap_left = IFG;
            end else if (gap_left > 1) begin
                gap_left--;
            end else begin
                gap_left = 0;
                if (sv) begin
                    if (len_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL start: frame triggered with nothing queued at %0t", $time);
                    end else begin
                        cur_left = len_q.pop_front();
                        obs.delete();
                    end
                end
            end
            total++;
            if ({gmii_tx_en, gmii_tx_er, gmii_txd, frame_done, underflow, s_ready} !== e) begin
                bad++;
                $display("FAIL wire @%0t: got en=%b er=%b txd=%02h done=%b uf=%b rdy=%b want en=%b er=%b txd=%02h done=%b uf=%b rdy=%b",
                         $time, gmii_tx_en, gmii_tx_er, gmii_txd, frame_done, underflow, s_ready,
                         e.en, e.er, e.d, e.done, e.uf, e.rdy);
            end
            if (gmii_tx_en) begin
                if (idle_run > 0) last_gap = idle_run;
                idle_run = 0;
                obs.push_back(gmii_txd);
            end else begin
                idle_run++;
            end
        end
    end

    // Called and returning on a falling edge; rst_at>=0 asserts reset once that many bytes are in.
    task automatic send_frame(input bq_t p, input int uf_at, input int rst_at);
        int i = 0;
        int guard = 0;
        logic rdy;
        push_frame(p, uf_at);
        s_valid = 1'b1; s_data = p[0]; s_last = (p.size() == 1);
        while (i < p.size()) begin
            rdy = s_ready;
            if (rst_at >= 0 && i == rst_at && rdy) begin
                #1 rst = 1'b1;
                #1;
                chk("async_rst_tx_en", {31'h0, gmii_tx_en}, 0);
                chk("async_rst_txd", {24'h0, gmii_txd}, 0);
                s_valid = 1'b0; s_last = 1'b0;
                repeat (3) @(negedge gmii_tx_clk);
                rst = 1'b0;
                return;
            end
            @(negedge gmii_tx_clk);
            guard++;
            if (guard > 5000) begin
                total++; bad++;
                $display("FAIL send_timeout: %0d of %0d bytes accepted", i, p.size());
                break;
            end
            if (rdy) begin
                i++;
                if (uf_at > 0 && i == uf_at) begin
                    s_valid = 1'b0; s_last = 1'b0;
                    @(negedge gmii_tx_clk);
                    break;
                end
                if (i < p.size()) begin s_data = p[i]; s_last = (i == p.size() - 1); end
            end
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((cur_left != 0 || len_q.size() != 0) && g < 3000) begin
            @(negedge gmii_tx_clk);
            g++;
        end
        chk("drain_timeout", (g >= 3000), 0);
    endtask

    function automatic bq_t rand_payload(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bq_t p, q;
        int len, uf;
        #5;
        chk("rst_tx_en", {31'h0, gmii_tx_en}, 0);
        chk("rst_txd", {24'h0, gmii_txd}, 0);
        chk("rst_tx_er", {31'h0, gmii_tx_er}, 0);
        chk("rst_s_ready", {31'h0, s_ready}, 0);
        chk("rst_done_uf", {30'h0, frame_done, underflow}, 0);
        repeat (2) @(negedge gmii_tx_clk);
        rst = 1'b0;

        p = {};
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
        chk("model_crc_check", crc32_ref(p), 32'hCBF43926);
        send_frame(p, 0, -1);
        wait_idle();
`ifdef GMII_TX_PAD_EN
        chk("ascii_len", obs.size(), 72);
`else
        chk("ascii_len", obs.size(), 21);
        if (obs.size() == 21) begin
            chk("ascii_fcs0", {24'h0, obs[17]}, 32'h26);
            chk("ascii_fcs1", {24'h0, obs[18]}, 32'h39);
            chk("ascii_fcs2", {24'h0, obs[19]}, 32'hF4);
            chk("ascii_fcs3", {24'h0, obs[20]}, 32'hCB);
        end
`endif

        send_frame(rand_payload(14), 0, -1);
        wait_idle();
`ifdef GMII_TX_PAD_EN
        chk("short_len", obs.size(), 72);
`else
        chk("short_len", obs.size(), 26);
`endif

        p = rand_payload(64);
        q = rand_payload(64);
        send_frame(p, 0, -1);
        send_frame(q, 0, -1);
        wait_idle();
        chk("b2b_gap", last_gap, IFG);

        send_frame(rand_payload(40), 20, -1);
        wait_idle();
        chk("uf_len", obs.size(), P + 1 + 20 + 1);

        repeat (100) @(negedge gmii_tx_clk);

        send_frame(rand_payload(50), 0, 30);
        send_frame(rand_payload(20), 0, -1);
        wait_idle();
        chk("post_rst_len", obs.size(), `ifdef GMII_TX_PAD_EN 72 `else P + 1 + 20 + 4 `endif);

        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 80);
            uf = (len >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
            repeat ($urandom_range(0, 15)) @(negedge gmii_tx_clk);
            send_frame(rand_payload(len), uf, -1);
        end
        wait_idle();
        repeat (20) @(negedge gmii_tx_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
